// File: rtl/ocx_leaf_regfile_fifo_ctl_pkg.sv
// Shared helpers for the regfile-backed FIFO controller.
// Holds no types; only the pointer advance used by both queue pointers.
package ocx_leaf_regfile_fifo_ctl_pkg;

  // Advance a pointer by one, wrapping from depth-1 back to 0.
  // Pointers are carried as 32 bits here so any pointer width can use it.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ocx_leaf_inferd_regfile.sv
// Simple dual-port inferred regfile.
// Port A: synchronous write (clka, ena, addra, dina).
// Port B: synchronous read with registered output (clkb, enb, addrb, doutb);
//         rstb (active-low, synchronous) clears only the output register.
// The array itself is not reset.
module ocx_leaf_inferd_regfile #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 576,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clka,
  input  logic                  ena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [WIDTH-1:0]      dina,
  input  logic                  clkb,
  input  logic                  rstb,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [WIDTH-1:0]      doutb
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clka) begin
    if (ena) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (!rstb)    doutb <= '0;
    else if (enb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/ocx_leaf_regfile_fifo_ctl.sv
// FIFO controller around an inferred dual-port regfile.
// The regfile's registered read output doubles as the output stage, so the
// queue holds DEPTH words in the array plus one word presented on pop_data.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous clear, wins over push and pop
//   push_valid/ready/data producer handshake
//   pop_valid/ready/data  consumer handshake (pop_data = regfile doutb)
//   level                 words held in the array, output stage excluded
module ocx_leaf_regfile_fifo_ctl
  import ocx_leaf_regfile_fifo_ctl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 576,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [WIDTH-1:0]      pop_data,
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  rd_issue;

  // push_ready depends only on the level register, never on pop_ready.
  assign push_ready = (level != LEVEL_FULL);
  assign push       = push_valid && push_ready && !flush;
  // Refill the output stage whenever it is empty or being consumed.
  assign rd_issue   = (level != '0) && (!pop_valid || pop_ready) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pop_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pop_valid <= 1'b0;
    end else begin
      if (push)     wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), DEPTH));
      if (rd_issue) rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), DEPTH));

      case ({push, rd_issue})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase

      if (rd_issue)                    pop_valid <= 1'b1;
      else if (pop_valid && pop_ready) pop_valid <= 1'b0;
    end
  end

  ocx_leaf_inferd_regfile #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clka  (clk),
    .ena   (push),
    .addra (wr_ptr),
    .dina  (push_data),
    .clkb  (clk),
    .rstb  (rst_n),
    .enb   (rd_issue),
    .addrb (rd_ptr),
    .doutb (pop_data)
  );

  // A read only happens with level > 0 and a write only with level < DEPTH,
  // so the two pointers can never coincide when both ports fire.
  a_no_same_entry: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && rd_issue && (wr_ptr == rd_ptr)));

endmodule

// File: tb/tb_ocx_leaf_regfile_fifo_ctl.sv
module tb_ocx_leaf_regfile_fifo_ctl;
  localparam int W = 576;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         push_valid;
  logic         pop_ready;
  logic [W-1:0] push_data;

  logic         push_ready_a, pop_valid_a;
  logic [W-1:0] pop_data_a;
  logic [4:0]   level_a;
  logic         push_ready_b, pop_valid_b;
  logic [W-1:0] pop_data_b;
  logic [4:0]   level_b;

  always #5 clk = ~clk;

  ocx_leaf_regfile_fifo_ctl #(.DEPTH(16), .WIDTH(W), .ADDR_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready_a), .push_data(push_data),
    .pop_valid(pop_valid_a), .pop_ready(pop_ready), .pop_data(pop_data_a),
    .level(level_a));

  ocx_leaf_regfile_fifo_ctl #(.DEPTH(12), .WIDTH(W), .ADDR_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready_b), .push_data(push_data),
    .pop_valid(pop_valid_b), .pop_ready(pop_ready), .pop_data(pop_data_b),
    .level(level_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model per DUT: queue of words in the array plus the output stage.
  logic [W-1:0] mq [2][$];
  logic         mv [2];
  logic [W-1:0] md [2];
  int           mwr [2];
  int           mrd [2];
  int           pushes [2];
  int           pops [2];

  function automatic logic [W-1:0] rand_word(input int tag);
    logic [W-1:0] w;
    for (int j = 0; j < W/32; j++) w[j*32 +: 32] = $urandom();
    w[15:0] = 16'(tag);
    return w;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mv[k] = 1'b0;
      mwr[k] = 0;
      mrd[k] = 0;
      pushes[k] = 0;
      pops[k] = 0;
    end
  endtask

  // Drive one cycle of inputs (called at negedge), let the edge happen,
  // advance the models, and return at the following negedge.
  task automatic step(input logic pv, input logic [W-1:0] d, input logic pr, input logic fl);
    push_valid = pv; push_data = d; pop_ready = pr; flush = fl;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int dep;
      bit pu, rd;
      dep = (k == 0) ? 16 : 12;
      pu = pv && !fl && (mq[k].size() != dep);
      rd = !fl && (mq[k].size() != 0) && (!mv[k] || pr);
      if (fl) begin
        mq[k].delete(); mv[k] = 1'b0; mwr[k] = 0; mrd[k] = 0;
      end else begin
        if (mv[k] && pr) begin mv[k] = 1'b0; pops[k]++; end
        if (rd) begin md[k] = mq[k].pop_front(); mv[k] = 1'b1; mrd[k] = (mrd[k] + 1) % dep; end
        if (pu) begin mq[k].push_back(d); mwr[k] = (mwr[k] + 1) % dep; pushes[k]++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0; push_data = '0;
    @(posedge clk);
    @(posedge clk);
    model_clear();
    md[0] = '0; md[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (push_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got %0b want 1", push_ready_a); end
    n_tests++; if (pop_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid got %0b want 0", pop_valid_a); end
    n_tests++; if (level_a !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_a); end
    n_tests++; if (pop_data_a !== '0) begin n_fail++; $display("FAIL reset_pop_data got %0h want 0", pop_data_a); end
    n_tests++; if (dut_a.wr_ptr !== 4'd0 || dut_a.rd_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", dut_a.wr_ptr, dut_a.rd_ptr); end
    n_tests++; if (push_ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready_b got %0b want 1", push_ready_b); end
  endtask

  task automatic test_first_word();
    do_reset();
    step(1'b1, W'(1), 1'b1, 1'b0);
    n_tests++; if (pop_valid_a !== 1'b0) begin n_fail++; $display("FAIL first_valid_e1 got %0b want 0", pop_valid_a); end
    n_tests++; if (level_a !== 5'd1) begin n_fail++; $display("FAIL first_level_e1 got %0d want 1", level_a); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (pop_valid_a !== 1'b1) begin n_fail++; $display("FAIL first_valid_e2 got %0b want 1", pop_valid_a); end
    n_tests++; if (pop_data_a !== W'(1)) begin n_fail++; $display("FAIL first_data got %0h want 1", pop_data_a); end
    n_tests++; if (level_a !== 5'd0) begin n_fail++; $display("FAIL first_level_e2 got %0d want 0", level_a); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (pop_valid_a !== 1'b0) begin n_fail++; $display("FAIL first_drained got %0b want 0", pop_valid_a); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      int exp_lvl;
      step(1'b1, W'(i), 1'b0, 1'b0);
      exp_lvl = (i == 0) ? 1 : ((i < 16) ? i : 16);
      n_tests++; if (level_a !== 5'(exp_lvl)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level_a, exp_lvl); end
      n_tests++; if (push_ready_a !== (exp_lvl != 16)) begin n_fail++; $display("FAIL fill_push_ready[%0d] got %0b want %0b", i, push_ready_a, exp_lvl != 16); end
    end
    for (int i = 0; i < 17; i++) begin
      n_tests++; if (pop_valid_a !== 1'b1 || pop_data_a !== W'(i)) begin n_fail++; $display("FAIL fill_drain[%0d] got v=%0b d=%0h want v=1 d=%0h", i, pop_valid_a, pop_data_a, i); end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_tests++; if (pop_valid_a !== 1'b0 || level_a !== 5'd0) begin n_fail++; $display("FAIL fill_empty got v=%0b lvl=%0d want v=0 lvl=0", pop_valid_a, level_a); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] steady;
    do_reset();
    steady = '0;
    for (int i = 0; i <= 100; i++) begin
      step(i < 100, W'(32'h1000 + i), 1'b1, 1'b0);
      if (i >= 1) begin
        n_tests++; if (pop_valid_a !== 1'b1 || pop_data_a !== W'(32'h1000 + i - 1)) begin n_fail++; $display("FAIL b2b_word[%0d] got v=%0b d=%0h want v=1 d=%0h", i, pop_valid_a, pop_data_a, 32'h1000 + i - 1); end
        n_tests++; if (level_a !== 5'(mq[0].size())) begin n_fail++; $display("FAIL b2b_level[%0d] got %0d want %0d", i, level_a, mq[0].size()); end
      end
      if (i == 1) steady = level_a;
      if (i > 1 && i < 100) begin
        n_tests++; if (level_a !== steady) begin n_fail++; $display("FAIL b2b_level_const[%0d] got %0d want %0d", i, level_a, steady); end
      end
    end
  endtask

  task automatic test_random_stalls();
    int cyc;
    int tag;
    do_reset();
    cyc = 0;
    tag = 0;
    while (pops[1] < 40 && cyc < 800) begin
      logic pv, pr, hold;
      logic [W-1:0] prev;
      pv = (pushes[1] < 40) && ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 2) != 0);
      hold = pop_valid_b && !pr;
      prev = pop_data_b;
      step(pv, rand_word(tag), pr, 1'b0);
      tag++;
      cyc++;
      n_tests++; if (pop_valid_b !== mv[1]) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", cyc, pop_valid_b, mv[1]); end
      n_tests++; if (level_b !== 5'(mq[1].size())) begin n_fail++; $display("FAIL rnd_level[%0d] got %0d want %0d", cyc, level_b, mq[1].size()); end
      if (mv[1]) begin
        n_tests++; if (pop_data_b !== md[1]) begin n_fail++; $display("FAIL rnd_data[%0d] got %0h want %0h", cyc, pop_data_b, md[1]); end
      end
      if (hold) begin
        n_tests++; if (pop_data_b !== prev) begin n_fail++; $display("FAIL rnd_stall_stable[%0d] got %0h want %0h", cyc, pop_data_b, prev); end
      end
      n_tests++; if (dut_b.wr_ptr !== 4'(mwr[1]) || dut_b.rd_ptr !== 4'(mrd[1])) begin n_fail++; $display("FAIL rnd_ptrs[%0d] got %0d/%0d want %0d/%0d", cyc, dut_b.wr_ptr, dut_b.rd_ptr, mwr[1], mrd[1]); end
      n_tests++; if (level_a !== 5'(mq[0].size()) || pop_valid_a !== mv[0]) begin n_fail++; $display("FAIL rnd_a_state[%0d] got lvl=%0d v=%0b want lvl=%0d v=%0b", cyc, level_a, pop_valid_a, mq[0].size(), mv[0]); end
    end
    n_tests++; if (pops[1] != 40) begin n_fail++; $display("FAIL rnd_timeout got %0d pops want 40", pops[1]); end
    n_tests++; if (dut_b.wr_ptr !== 4'd4 || dut_b.rd_ptr !== 4'd4) begin n_fail++; $display("FAIL rnd_wrap_end got %0d/%0d want 4/4", dut_b.wr_ptr, dut_b.rd_ptr); end
  endtask

  task automatic test_flush();
    int guard;
    do_reset();
    guard = 0;
    while (mq[0].size() != 5 && guard < 20) begin
      step(1'b1, W'(32'h200 + guard), 1'b0, 1'b0);
      guard++;
    end
    n_tests++; if (level_a !== 5'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d want 5", level_a); end
    step(1'b1, W'(32'hCC), 1'b0, 1'b1);
    n_tests++; if (level_a !== 5'd0 || pop_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_clear got lvl=%0d v=%0b want lvl=0 v=0", level_a, pop_valid_a); end
    n_tests++; if (dut_a.wr_ptr !== 4'd0 || dut_a.rd_ptr !== 4'd0) begin n_fail++; $display("FAIL flush_ptrs got %0d/%0d want 0/0", dut_a.wr_ptr, dut_a.rd_ptr); end
    step(1'b1, W'(32'hAB), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (pop_valid_a !== 1'b1 || pop_data_a !== W'(32'hAB)) begin n_fail++; $display("FAIL flush_next_word got v=%0b d=%0h want v=1 d=ab", pop_valid_a, pop_data_a); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (pop_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_no_extra got %0b want 0", pop_valid_a); end
  endtask

  task automatic test_reset_midstream();
    int guard;
    do_reset();
    guard = 0;
    while (mq[0].size() != 7 && guard < 20) begin
      step(1'b1, W'(32'h300 + guard), 1'b0, 1'b0);
      guard++;
    end
    n_tests++; if (level_a !== 5'd7 || pop_data_a !== W'(32'h300)) begin n_fail++; $display("FAIL mid_pre got lvl=%0d d=%0h want lvl=7 d=300", level_a, pop_data_a); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (pop_valid_a !== 1'b0 || level_a !== 5'd0 || push_ready_a !== 1'b1) begin n_fail++; $display("FAIL mid_async got v=%0b lvl=%0d rdy=%0b want 0/0/1", pop_valid_a, level_a, push_ready_a); end
    @(posedge clk);
    #1;
    n_tests++; if (pop_data_a !== '0) begin n_fail++; $display("FAIL mid_pop_data got %0h want 0", pop_data_a); end
    model_clear();
    md[0] = '0; md[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, W'(32'h55), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (pop_valid_a !== 1'b1 || pop_data_a !== W'(32'h55) || level_a !== 5'd0) begin n_fail++; $display("FAIL mid_resume got v=%0b d=%0h lvl=%0d want 1/55/0", pop_valid_a, pop_data_a, level_a); end
  endtask

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0; push_data = '0;
    test_reset();
    test_first_word();
    test_fill();
    test_back_to_back();
    test_random_stalls();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
